// File: rtl/seg_scan_ctrl_if.sv
// Digit write port of the seven-segment scan controller.
// The master presents a digit index and value; the slave accepts on valid && ready.
interface seg_scan_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_idx;
  logic [3:0] wr_val;

  modport master (output wr_valid, wr_idx, wr_val, input wr_ready);
  modport slave  (input wr_valid, wr_idx, wr_val, output wr_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with a write port,
// sequenced clear and per-digit enable mask.
//
// state | meaning
// SHOW  | current digit driven for DIV cycles
// BLANK | one-cycle all-off gap before the next digit
module seg_scan_ctrl #(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_ctrl_if.slave    wr,
  input  logic              clr,
  output logic              clr_busy,
  input  logic [7:0]        en_mask,
  output logic [7:0]        dig_sel,
  output logic [7:0]        seg_out,
  output logic              frame_done
);

  typedef enum logic {SHOW, BLANK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       dig_sel_d, seg_out_d;
  logic             frame_done_d;

  logic [3:0]       digit_q [8];
  logic [2:0]       clr_ptr;

  function automatic logic [7:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 8'hFC;
      4'h1: decode = 8'h60;
      4'h2: decode = 8'hDA;
      4'h3: decode = 8'hF2;
      4'h4: decode = 8'h66;
      4'h5: decode = 8'hB6;
      4'h6: decode = 8'hBE;
      4'h7: decode = 8'hE0;
      4'h8: decode = 8'hFE;
      4'h9: decode = 8'hF6;
      4'hA: decode = 8'hEE;
      4'hB: decode = 8'h3E;
      4'hC: decode = 8'h9C;
      4'hD: decode = 8'h7A;
      4'hE: decode = 8'h9E;
      default: decode = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SHOW;
      cnt_q      <= '0;
      idx_q      <= '0;
      dig_sel    <= '0;
      seg_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dig_sel    <= dig_sel_d;
      seg_out    <= seg_out_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SHOW;
        cnt_d   = '0;
        idx_d   = idx_q + 3'd1;
      end
    endcase
  end

  // Outputs are computed from the current scan state and registered above.
  always_comb begin
    dig_sel_d    = '0;
    seg_out_d    = '0;
    frame_done_d = (state_q == BLANK) && (idx_q == 3'd7);
    if (state_q == SHOW && en_mask[idx_q]) begin
      dig_sel_d = 8'(1) << idx_q;
      seg_out_d = decode(digit_q[idx_q]);
    end
  end

  assign wr.wr_ready = !clr_busy && !clr;

  // A clear owns the digit registers for 8 cycles; writes are held off meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
      clr_busy <= 1'b0;
      clr_ptr  <= '0;
    end else if (clr_busy) begin
      digit_q[clr_ptr] <= '0;
      clr_ptr          <= clr_ptr + 3'd1;
      if (clr_ptr == 3'd7) clr_busy <= 1'b0;
    end else if (clr) begin
      clr_busy <= 1'b1;
      clr_ptr  <= '0;
    end else if (wr.wr_valid) begin
      digit_q[wr.wr_idx] <= wr.wr_val;
    end
  end

endmodule
